// File: rtl/md_unit_if.sv
// Operand, control and result bundle between the EX stage and the multiply/divide unit.
interface md_unit_if;
  logic        StartE;
  logic        MDE;
  logic        MDSignE;
  logic [1:0]  AccumE;
  logic        HLWriteE;
  logic        HLSelE;
  logic [31:0] SrcAE;
  logic [31:0] SrcBE;
  logic        AbortE;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output StartE, MDE, MDSignE, AccumE, HLWriteE, HLSelE, SrcAE, SrcBE, AbortE,
    input  Busy, Done, HI, LO
  );

  modport slave (
    input  StartE, MDE, MDSignE, AccumE, HLWriteE, HLSelE, SrcAE, SrcBE, AbortE,
    output Busy, Done, HI, LO
  );
endinterface

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit holding HI/LO; computes at Start, commits after a fixed latency.
// Optional madd/msub accumulation into HI/LO is enabled by defining MD_ACCUM_EN.
module md_unit #(
  parameter int unsigned MUL_CYCLES = 5,
  parameter int unsigned DIV_CYCLES = 10
) (
  input logic       clk,
  input logic       reset,
  md_unit_if.slave  bus
);

  localparam int unsigned MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [31:0]      ph, ph_n, pl, pl_n;
  logic [31:0]      hi, hi_n, lo, lo_n;
  logic             done, done_n;
  logic             skip, skip_n;

  logic [63:0] ext_a, ext_b, product, mul_res, result;
  logic        neg_a, neg_b, div_zero;
  logic [31:0] mag_a, mag_b, div_b, mag_q, mag_r, quot, rem;

  // Datapath: full result is formed combinationally and latched at Start.
  always_comb begin
    ext_a    = bus.MDSignE ? {{32{bus.SrcAE[31]}}, bus.SrcAE} : {32'h0, bus.SrcAE};
    ext_b    = bus.MDSignE ? {{32{bus.SrcBE[31]}}, bus.SrcBE} : {32'h0, bus.SrcBE};
    product  = ext_a * ext_b;

    neg_a    = bus.MDSignE & bus.SrcAE[31];
    neg_b    = bus.MDSignE & bus.SrcBE[31];
    mag_a    = neg_a ? (~bus.SrcAE + 32'd1) : bus.SrcAE;
    mag_b    = neg_b ? (~bus.SrcBE + 32'd1) : bus.SrcBE;
    div_zero = (bus.SrcBE == 32'd0);
    div_b    = div_zero ? 32'd1 : mag_b;
    mag_q    = mag_a / div_b;
    mag_r    = mag_a % div_b;
    quot     = (neg_a ^ neg_b) ? (~mag_q + 32'd1) : mag_q;
    rem      = neg_a ? (~mag_r + 32'd1) : mag_r;

`ifdef MD_ACCUM_EN
    case (bus.AccumE)
      2'b01:   mul_res = {hi, lo} + product;
      2'b10:   mul_res = {hi, lo} - product;
      default: mul_res = product;
    endcase
`else
    mul_res = product;
`endif

    result = bus.MDE ? {rem, quot} : mul_res;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      ph    <= '0;
      pl    <= '0;
      hi    <= '0;
      lo    <= '0;
      done  <= 1'b0;
      skip  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      ph    <= ph_n;
      pl    <= pl_n;
      hi    <= hi_n;
      lo    <= lo_n;
      done  <= done_n;
      skip  <= skip_n;
    end
  end

  // Abort outranks Start/HLWrite in IDLE and cancels the commit in RUN.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ph_n    = ph;
    pl_n    = pl;
    hi_n    = hi;
    lo_n    = lo;
    done_n  = 1'b0;
    skip_n  = skip;
    case (state)
      IDLE: begin
        if (!bus.AbortE) begin
          if (bus.StartE) begin
            {ph_n, pl_n} = result;
            cnt_n        = bus.MDE ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MUL_CYCLES - 1);
            skip_n       = bus.MDE & div_zero;
            state_n      = RUN;
          end else if (bus.HLWriteE) begin
            if (bus.HLSelE) hi_n = bus.SrcAE;
            else            lo_n = bus.SrcAE;
          end
        end
      end
      RUN: begin
        if (bus.AbortE) begin
          state_n = IDLE;
        end else if (cnt != '0) begin
          cnt_n = cnt - CNT_W'(1);
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          if (!skip) begin
            hi_n = ph;
            lo_n = pl;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.Busy = (state == RUN);
  assign bus.Done = done;
  assign bus.HI   = hi;
  assign bus.LO   = lo;

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic HI/LO reference model.
module tb_md_unit;

  localparam int unsigned MUL_N = 5;
  localparam int unsigned DIV_N = 10;
`ifdef MD_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  md_unit_if bus ();

  md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    bus.StartE   = 1'b0;
    bus.HLWriteE = 1'b0;
    bus.AbortE   = 1'b0;
  endtask

  // Reference result from plain 64-bit integer arithmetic (divisor assumed nonzero).
  function automatic logic [63:0] ref_result(input logic md, input logic sg, input logic [1:0] acc,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [63:0] hl);
    longint sa, sb;
    logic [63:0] p;
    sa = sg ? longint'($signed(a)) : longint'({32'h0, a});
    sb = sg ? longint'($signed(b)) : longint'({32'h0, b});
    if (md) begin
      p[31:0]  = 32'(sa / sb);
      p[63:32] = 32'(sa % sb);
    end else begin
      p = 64'(sa * sb);
      if (ACC_EN && acc == 2'b01) p = hl + p;
      else if (ACC_EN && acc == 2'b10) p = hl - p;
    end
    return p;
  endfunction

  task automatic run_op(input logic md, input logic sg, input logic [1:0] acc,
                        input logic [31:0] a, input logic [31:0] b,
                        input int abort_at, input bit hl_mid);
    int n, cyc, dn, exp_busy;
    bit aborted;
    logic [63:0] r;
    n = md ? DIV_N : MUL_N;
    r = (md && b == 32'd0) ? 64'd0 : ref_result(md, sg, acc, a, b, {m_hi, m_lo});
    bus.StartE   = 1'b1;
    bus.MDE      = md;
    bus.MDSignE  = sg;
    bus.AccumE   = acc;
    bus.SrcAE    = a;
    bus.SrcBE    = b;
    bus.HLWriteE = 1'($urandom_range(0, 1));
    bus.HLSelE   = 1'($urandom_range(0, 1));
    tick();
    clear_pulses();
    cyc = 0;
    dn  = 0;
    while (bus.Busy && cyc < 64) begin
      cyc++;
      if (hl_mid && cyc == 2) begin
        bus.HLWriteE = 1'b1;
        bus.HLSelE   = 1'b1;
        bus.SrcAE    = $urandom;
        bus.StartE   = 1'b1;
      end
      if (cyc == abort_at) bus.AbortE = 1'b1;
      tick();
      clear_pulses();
      if (bus.Done) dn++;
    end
    aborted  = (abort_at >= 1) && (abort_at <= n);
    exp_busy = aborted ? abort_at : n;
    chk("busy_len", 64'(cyc), 64'(exp_busy));
    chk("done_pulse", 64'(dn), aborted ? 64'd0 : 64'd1);
    if (!aborted && !(md && b == 32'd0)) {m_hi, m_lo} = r;
    chk("hi", 64'(bus.HI), 64'(m_hi));
    chk("lo", 64'(bus.LO), 64'(m_lo));
    tick();
    chk("done_clear", 64'(bus.Done), 64'd0);
  endtask

  task automatic mt(input logic sel, input logic [31:0] data);
    bus.HLWriteE = 1'b1;
    bus.HLSelE   = sel;
    bus.SrcAE    = data;
    tick();
    clear_pulses();
    if (sel) m_hi = data;
    else     m_lo = data;
    chk("mt_busy", 64'(bus.Busy), 64'd0);
    chk("mt_hi", 64'(bus.HI), 64'(m_hi));
    chk("mt_lo", 64'(bus.LO), 64'(m_lo));
    chk("mt_done", 64'(bus.Done), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b;
    logic [31:0] specials [4];
    specials[0] = 32'h8000_0000;
    specials[1] = 32'hFFFF_FFFF;
    specials[2] = 32'h0000_0001;
    specials[3] = 32'h7FFF_FFFF;

    reset = 1'b0;
    bus.MDE = 1'b0; bus.MDSignE = 1'b0; bus.AccumE = 2'b00; bus.HLSelE = 1'b0;
    bus.SrcAE = '0; bus.SrcBE = '0;
    clear_pulses();
    tick(); tick();
    chk("rst_hi", 64'(bus.HI), 64'd0);
    chk("rst_lo", 64'(bus.LO), 64'd0);
    chk("rst_busy", 64'(bus.Busy), 64'd0);
    chk("rst_done", 64'(bus.Done), 64'd0);
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;

    run_op(1'b0, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    chk("multu_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFE);
    chk("multu_lo", 64'(bus.LO), 64'h0000_0000_0000_0001);
    run_op(1'b0, 1'b1, 2'b00, 32'hFFFF_FFFD, 32'd7, 0, 1'b0);
    chk("mult_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    chk("mult_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFEB);
    run_op(1'b1, 1'b0, 2'b00, 32'd7, 32'd0, 0, 1'b0);
    chk("divz_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFEB);
    run_op(1'b1, 1'b1, 2'b00, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
    chk("div_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
    chk("div_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    run_op(1'b1, 1'b1, 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    chk("ovf_lo", 64'(bus.LO), 64'h0000_0000_8000_0000);
    chk("ovf_hi", 64'(bus.HI), 64'd0);

    mt(1'b0, 32'h1234_5678);
    mt(1'b1, 32'hCAFE_BABE);
    run_op(1'b1, 1'b0, 2'b00, 32'd9, 32'd0, 0, 1'b1);
    chk("mthi_in_run", 64'(bus.HI), 64'h0000_0000_CAFE_BABE);
    run_op(1'b1, 1'b1, 2'b00, 32'd100, 32'd3, 4, 1'b0);

    // Abort in IDLE suppresses both Start and HLWrite.
    bus.StartE = 1'b1; bus.HLWriteE = 1'b1; bus.AbortE = 1'b1; bus.SrcAE = 32'hDEAD_0000;
    tick();
    clear_pulses();
    chk("abort_idle_busy", 64'(bus.Busy), 64'd0);
    chk("abort_idle_hi", 64'(bus.HI), 64'(m_hi));
    chk("abort_idle_lo", 64'(bus.LO), 64'(m_lo));

    bus.StartE = 1'b1; bus.MDE = 1'b0; bus.SrcAE = 32'd123; bus.SrcBE = 32'd456;
    tick();
    clear_pulses();
    tick(); tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    chk("midrst_hi", 64'(bus.HI), 64'd0);
    chk("midrst_lo", 64'(bus.LO), 64'd0);
    chk("midrst_busy", 64'(bus.Busy), 64'd0);
    tick(); tick(); tick(); tick(); tick();
    chk("midrst_nodone", 64'(bus.Done), 64'd0);
    chk("midrst_hold_lo", 64'(bus.LO), 64'd0);

`ifdef MD_ACCUM_EN
    mt(1'b1, 32'd0);
    mt(1'b0, 32'd10);
    run_op(1'b0, 1'b1, 2'b01, 32'd3, 32'd4, 0, 1'b0);
    chk("madd_lo", 64'(bus.LO), 64'd22);
    run_op(1'b0, 1'b0, 2'b10, 32'd1, 32'h17, 0, 1'b0);
    chk("msub_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    chk("msub_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFF);
`endif

    for (int i = 0; i < 40; i++) begin
      int ab;
      a  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 3)] : $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(1, 17));
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 3)) : 0;
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), $urandom);
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             a, b, ab, (ab == 0) && ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multiply/divide unit for the EX stage. Directly downstream of the ID/EX control register.
- Consumes the EX-stage MD control bits (start, signedness, mul/div select, HI/LO write) together with the forwarded operands.
- Holds the architectural HI/LO registers and raises Busy so the hazard unit stalls mfhi/mflo/mult/div behind an operation still in flight.

Parameters:
- MUL_CYCLES, 5, busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, busy cycles for div/divu (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; state clears at a rising edge where reset==0.
- StartE  in  1  begin MD operation this cycle.
- MDE  in  1  0=multiply, 1=divide.
- MDSignE  in  1  1=signed operands, 0=unsigned.
- AccumE  in  2  00=plain, 01=accumulate add, 10=accumulate subtract, 11=reserved (treated as 00). Ignored unless MD_ACCUM_EN.
- HLWriteE  in  1  mthi/mtlo write.
- HLSelE  in  1  HLWrite target: 0=LO, 1=HI.
- SrcAE  in  32  rs operand / mthi-mtlo data.
- SrcBE  in  32  rt operand.
- AbortE  in  1  cancel in-flight op / suppress this cycle's Start and HLWrite (exception/interrupt).
- Busy  out  1  operation in flight.
- Done  out  1  one-cycle pulse in the cycle after HI/LO commit.
- HI  out  32  HI register.
- LO  out  32  LO register.

Behaviour:
- Reset values: HI=0, LO=0, Busy=0, Done=0, state IDLE, counter=0, pending result=0.
- FSM states: IDLE, RUN.
- IDLE with StartE=1 and AbortE=0:
  - Compute the 64-bit result from SrcAE/SrcBE and latch it into pending registers (PH, PL).
  - Load counter with N-1, where N = DIV_CYCLES if MDE else MUL_CYCLES.
  - Go to RUN.
- RUN, each edge:
  - counter!=0: decrement counter.
  - counter==0: HI<=PH, LO<=PL, go to IDLE, Done<=1 for the next cycle only.
- Timing: Start sampled at edge t0 gives Busy=1 for exactly N cycles after t0. HI/LO are new and Done=1 after edge t0+N.
- Busy is registered: Busy==(state==RUN).
- Multiply:
  - Signed: 64-bit product of the sign-extended operands.
  - Unsigned: product of the zero-extended operands.
  - Result: PH=product[63:32], PL=product[31:0].
- Divide:
  - PL=quotient truncated toward zero; PH=remainder with the sign of the dividend (SrcAE).
  - Signed 0x80000000 / 0xFFFFFFFF: PL=0x80000000, PH=0.
  - Divisor==0: the op still runs N cycles and pulses Done, but HI/LO are left unchanged.
- HLWriteE=1 in IDLE with StartE=0 and AbortE=0: write SrcAE to the selected register next edge. No Busy, no Done.
- StartE or HLWriteE while in RUN: ignored. The hazard unit must stall instead.
- StartE and HLWriteE in the same cycle: Start wins, HLWrite is dropped.
- AbortE=1:
  - In RUN: return to IDLE next edge, HI/LO untouched, no Done pulse.
  - In IDLE: Start and HLWrite that cycle are suppressed.
  - Abort has priority over everything except reset.
- reset==0 mid-operation: immediate (next-edge) return to the reset values. The pending result is discarded.

Optional Feature:
- Macro MD_ACCUM_EN.
- Defined:
  - With MDE=0 and AccumE=01: commit {HI,LO}+product (madd/maddu).
  - With MDE=0 and AccumE=10: commit {HI,LO}-product (msub/msubu).
  - The accumulation is modulo 2^64 and uses the HI/LO value sampled at the Start edge.
  - Latency is unchanged (MUL_CYCLES).
  - AccumE is ignored when MDE=1.
- Undefined: AccumE is unused. Every multiply overwrites HI/LO.

Test Plan:
- multu 0xFFFFFFFF x 0xFFFFFFFF -> Busy high exactly 5 cycles; then HI=0xFFFFFFFE, LO=0x00000001, Done pulses once.
- mult signed 0xFFFFFFFD (-3) x 7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB after 5 cycles. Then divu 7/0 -> Busy 10 cycles, HI/LO unchanged.
- div signed 0xFFFFFFF9 (-7) / 2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- mtlo 0x12345678 then mthi 0xCAFEBABE in IDLE -> LO and HI updated next edge, Busy stays 0. mthi asserted during RUN -> HI unchanged.
- div 100/3 started, AbortE pulsed on 4th busy cycle -> Busy drops next edge, HI/LO keep their prior values, no Done. reset=0 mid-mult -> HI=LO=0, Busy=0.
- (MD_ACCUM_EN) HI=0, LO=10; madd 3x4 -> LO=22. msubu 0x0 - 1x0x17 -> {HI,LO}=0xFFFFFFFF_FFFFFFFF... i.e. 22-23 wraps to HI=0xFFFFFFFF, LO=0xFFFFFFFF.
